// File: rtl/smem_store_unit.sv
// MEM/CURR entry store for the backward-extension pipeline, with a ready/valid drain of the MEM bank.
// Optional build macro SMEM_STORE_FWD_EN: same-cycle CURR write-to-read forwarding.
module smem_store_unit #(
  parameter int DEPTH = 128,
  parameter int DW    = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          wr_mem_valid,
  input  logic [6:0]    wr_mem_addr,
  input  logic [DW-1:0] wr_mem_data,
  input  logic          wr_curr_valid,
  input  logic [6:0]    wr_curr_addr,
  input  logic [DW-1:0] wr_curr_data,
  input  logic [6:0]    curr_rd_addr,
  output logic [DW-1:0] curr_rd_data,
  input  logic          drain_start,
  input  logic [6:0]    drain_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          drain_done,
  output logic          err_wr_busy
);

  typedef enum logic [1:0] {IDLE, RD, OUT} state_t;

  state_t        state;
  logic [6:0]    index;
  logic [6:0]    count;
  logic [DW-1:0] mem_bank  [DEPTH];
  logic [DW-1:0] curr_bank [DEPTH];

  assign busy = (state != IDLE);

  // Bank contents are deliberately outside reset.
  always_ff @(posedge clk) begin
    if (wr_mem_valid && !stall && state == IDLE)
      mem_bank[wr_mem_addr] <= wr_mem_data;
    if (wr_curr_valid && !stall)
      curr_bank[wr_curr_addr] <= wr_curr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      err_wr_busy <= 1'b0;
    else if (wr_mem_valid && !stall && state != IDLE)
      err_wr_busy <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      curr_rd_data <= '0;
    else if (!stall) begin
`ifdef SMEM_STORE_FWD_EN
      if (wr_curr_valid && wr_curr_addr == curr_rd_addr)
        curr_rd_data <= wr_curr_data;
      else
        curr_rd_data <= curr_bank[curr_rd_addr];
`else
      curr_rd_data <= curr_bank[curr_rd_addr];
`endif
    end
  end

  // Drain FSM: one RD cycle fetches the entry, OUT holds it until accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      index      <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        IDLE: begin
          if (drain_start) begin
            if (drain_count != 7'd0) begin
              count <= drain_count;
              index <= '0;
              state <= RD;
            end else begin
              drain_done <= 1'b1;
            end
          end
        end
        RD: begin
          out_data  <= mem_bank[index];
          out_valid <= 1'b1;
          out_last  <= (index == count - 7'd1);
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              drain_done <= 1'b1;
              state      <= IDLE;
            end else begin
              index <= index + 7'd1;
              state <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smem_store_unit.sv
// Directed bench for smem_store_unit: CURR-bank vector table plus hand-written drain sequences.
module tb_smem_store_unit;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          wr_mem_valid;
  logic [6:0]    wr_mem_addr;
  logic [DW-1:0] wr_mem_data;
  logic          wr_curr_valid;
  logic [6:0]    wr_curr_addr;
  logic [DW-1:0] wr_curr_data;
  logic [6:0]    curr_rd_addr;
  logic [DW-1:0] curr_rd_data;
  logic          drain_start;
  logic [6:0]    drain_count;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          drain_done;
  logic          err_wr_busy;

  smem_store_unit #(.DEPTH(128), .DW(DW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .wr_mem_valid(wr_mem_valid), .wr_mem_addr(wr_mem_addr), .wr_mem_data(wr_mem_data),
    .wr_curr_valid(wr_curr_valid), .wr_curr_addr(wr_curr_addr), .wr_curr_data(wr_curr_data),
    .curr_rd_addr(curr_rd_addr), .curr_rd_data(curr_rd_data),
    .drain_start(drain_start), .drain_count(drain_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .drain_done(drain_done), .err_wr_busy(err_wr_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wv;
    logic          st;
    logic [6:0]    wa;
    logic [DW-1:0] wd;
    logic [6:0]    ra;
    logic          chk;
    logic [DW-1:0] exp;
  } vec_t;

`ifdef SMEM_STORE_FWD_EN
  localparam logic [DW-1:0] SAME_ADDR_EXP = 256'h55;
`else
  localparam logic [DW-1:0] SAME_ADDR_EXP = 256'h33;
`endif

  vec_t vecs[11];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mem_wr(input logic [6:0] a, input logic [DW-1:0] d);
    wr_mem_valid = 1'b1;
    wr_mem_addr  = a;
    wr_mem_data  = d;
    tick();
    wr_mem_valid = 1'b0;
  endtask

  task automatic start_drain(input logic [6:0] n);
    drain_start = 1'b1;
    drain_count = n;
    tick();
    drain_start = 1'b0;
  endtask

  initial begin
    int beats;
    int dones;
    logic [DW-1:0] ex3 [3];

    rst = 1'b0; stall = 1'b0; out_ready = 1'b0;
    wr_mem_valid = 1'b0; wr_mem_addr = '0; wr_mem_data = '0;
    wr_curr_valid = 1'b0; wr_curr_addr = '0; wr_curr_data = '0;
    curr_rd_addr = '0; drain_start = 1'b0; drain_count = '0;

    vecs[0]  = '{1'b1, 1'b0, 7'd5, 256'h11, 7'd0, 1'b0, 256'h0};
    vecs[1]  = '{1'b1, 1'b1, 7'd5, 256'hAA, 7'd5, 1'b0, 256'h0};
    vecs[2]  = '{1'b0, 1'b0, 7'd0, 256'h0,  7'd5, 1'b1, 256'h11};
    vecs[3]  = '{1'b1, 1'b0, 7'd6, 256'h66, 7'd5, 1'b1, 256'h11};
    vecs[4]  = '{1'b0, 1'b1, 7'd0, 256'h0,  7'd6, 1'b1, 256'h11};
    vecs[5]  = '{1'b0, 1'b0, 7'd0, 256'h0,  7'd6, 1'b1, 256'h66};
    vecs[6]  = '{1'b1, 1'b0, 7'd9, 256'h33, 7'd6, 1'b1, 256'h66};
    vecs[7]  = '{1'b1, 1'b0, 7'd9, 256'h55, 7'd9, 1'b1, SAME_ADDR_EXP};
    vecs[8]  = '{1'b0, 1'b0, 7'd0, 256'h0,  7'd9, 1'b1, 256'h55};
    vecs[9]  = '{1'b1, 1'b1, 7'd9, 256'hEE, 7'd9, 1'b1, 256'h55};
    vecs[10] = '{1'b0, 1'b0, 7'd0, 256'h0,  7'd9, 1'b1, 256'h55};

    // Reset state
    tick(); tick();
    check("rst_busy", {255'b0, busy}, 256'h0);
    check("rst_out_valid", {255'b0, out_valid}, 256'h0);
    check("rst_out_last", {255'b0, out_last}, 256'h0);
    check("rst_drain_done", {255'b0, drain_done}, 256'h0);
    check("rst_err", {255'b0, err_wr_busy}, 256'h0);
    check("rst_out_data", out_data, 256'h0);
    check("rst_curr_rd_data", curr_rd_data, 256'h0);
    rst = 1'b1;

    // CURR bank table: stall masking, read hold, same-address behaviour
    for (int i = 0; i < 11; i++) begin
      wr_curr_valid = vecs[i].wv;
      stall         = vecs[i].st;
      wr_curr_addr  = vecs[i].wa;
      wr_curr_data  = vecs[i].wd;
      curr_rd_addr  = vecs[i].ra;
      tick();
      if (vecs[i].chk) check($sformatf("curr_vec%0d", i), curr_rd_data, vecs[i].exp);
    end
    wr_curr_valid = 1'b0; stall = 1'b0;

    // Four-entry drain at full rate
    for (int k = 0; k < 4; k++) mem_wr(7'(k), DW'(k));
    out_ready = 1'b1;
    start_drain(7'd4);
    check("drain4_T1_valid", {255'b0, out_valid}, 256'h0);
    check("drain4_T1_busy", {255'b0, busy}, 256'h1);
    tick();
    check("drain4_T2_valid", {255'b0, out_valid}, 256'h1);
    check("drain4_T2_data", out_data, 256'h0);
    beats = 1; dones = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid) begin
        check("drain4_data", out_data, DW'(beats));
        check("drain4_last", {255'b0, out_last}, {255'b0, beats == 3});
        beats++;
      end
      if (drain_done) dones++;
    end
    check("drain4_beats", DW'(beats), 256'd4);
    check("drain4_done_pulses", DW'(dones), 256'd1);
    check("drain4_idle", {255'b0, busy}, 256'h0);

    // Two-entry drain with backpressure, stray drain_start and stall
    mem_wr(7'd0, 256'h100);
    mem_wr(7'd1, 256'h101);
    out_ready = 1'b0;
    start_drain(7'd2);
    tick();
    stall = 1'b1;
    drain_start = 1'b1; drain_count = 7'd5;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", {255'b0, out_valid}, 256'h1);
      check("bp_data", out_data, 256'h100);
      tick();
      drain_start = 1'b0;
    end
    stall = 1'b0;
    out_ready = 1'b1;
    beats = 0; dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        check("bp_beat_data", out_data, 256'h100 + DW'(beats));
        beats++;
      end
      if (drain_done) dones++;
      tick();
    end
    check("bp_beats", DW'(beats), 256'd2);
    check("bp_done_pulses", DW'(dones), 256'd1);

    // MEM write during a drain is dropped and flagged
    ex3[0] = 256'h100; ex3[1] = 256'h101; ex3[2] = 256'h2;
    out_ready = 1'b0;
    start_drain(7'd3);
    mem_wr(7'd2, 256'hDEAD);
    check("err_set", {255'b0, err_wr_busy}, 256'h1);
    out_ready = 1'b1;
    beats = 0; dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid && beats < 3) begin
        check($sformatf("busywr_data%0d", beats), out_data, ex3[beats]);
        beats++;
      end
      if (drain_done) dones++;
      tick();
    end
    check("busywr_beats", DW'(beats), 256'd3);
    check("busywr_done_pulses", DW'(dones), 256'd1);
    check("err_sticky", {255'b0, err_wr_busy}, 256'h1);

    // Reset while in OUT, then a zero-length drain right after reset
    out_ready = 1'b0;
    start_drain(7'd1);
    tick();
    check("abort_in_out", {255'b0, out_valid}, 256'h1);
    rst = 1'b0;
    tick();
    check("abort_busy", {255'b0, busy}, 256'h0);
    check("abort_valid", {255'b0, out_valid}, 256'h0);
    check("abort_no_done", {255'b0, drain_done}, 256'h0);
    check("abort_err_clr", {255'b0, err_wr_busy}, 256'h0);
    rst = 1'b1;
    start_drain(7'd0);
    check("zero_done", {255'b0, drain_done}, 256'h1);
    check("zero_busy", {255'b0, busy}, 256'h0);
    check("zero_valid", {255'b0, out_valid}, 256'h0);
    tick();
    check("zero_done_pulse_end", {255'b0, drain_done}, 256'h0);
    check("zero_valid_after", {255'b0, out_valid}, 256'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/smem_store_unit.md
SMEM_STORE_UNIT -- requirements
Module: smem_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, 128, entries per bank; address width fixed at 7 bits.
REQ-002 SHALL have parameter DW, 256, entry width, packed {info,x2,x1,x0}, 64 bits each.
REQ-003 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port stall  in  1  pipeline stall from the backward-extension stages.
REQ-006 SHALL have ports wr_mem_valid in 1, wr_mem_addr in 7, wr_mem_data in DW: MEM-bank write from stage1.
REQ-007 SHALL have ports wr_curr_valid in 1, wr_curr_addr in 7, wr_curr_data in DW: CURR-bank write from stage1.
REQ-008 SHALL have ports curr_rd_addr in 7 and curr_rd_data out DW: CURR-bank read for the next backward iteration.
REQ-009 SHALL have ports drain_start in 1 and drain_count in 7: request to stream MEM entries 0..drain_count-1.
REQ-010 SHALL have ports out_valid out 1, out_ready in 1, out_data out DW, out_last out 1: drain stream.
REQ-011 SHALL have ports busy out 1 (FSM not IDLE), drain_done out 1 (one-cycle pulse), err_wr_busy out 1 (sticky).

Function
REQ-012 SHALL write MEM bank at wr_mem_addr when wr_mem_valid=1, stall=0 and FSM is IDLE.
REQ-013 SHALL drop MEM writes while busy=1 and set err_wr_busy, held until reset.
REQ-014 SHALL write CURR bank when wr_curr_valid=1 and stall=0, regardless of FSM state.
REQ-015 SHALL ignore all writes while stall=1; stage1 holding its valids during a stall produces no extra writes.
REQ-016 SHALL return curr_rd_data one cycle after curr_rd_addr is presented (registered read); the read register holds its value while stall=1.
REQ-017 SHALL implement FSM states IDLE, RD, OUT.
REQ-018 IDLE: drain_start=1 with drain_count>0 SHALL latch the count, clear index to 0 and go to RD.
REQ-019 IDLE: drain_start=1 with drain_count=0 SHALL stay IDLE and pulse drain_done in the next cycle.
REQ-020 RD SHALL read MEM[index] and go to OUT next cycle; out_valid is asserted in OUT.
REQ-021 OUT SHALL hold out_valid and out_data stable until out_ready=1; out_last=1 when index=count-1.
REQ-022 On an OUT handshake SHALL go to IDLE with a drain_done pulse if last, else increment index and go to RD.
REQ-023 drain_start outside IDLE SHALL be ignored.
REQ-024 The drain FSM SHALL be unaffected by stall.
REQ-025 Latency SHALL be: drain_start at cycle T gives first out_valid at T+2; peak rate one entry per 2 cycles.
REQ-026 A CURR write and a CURR read at the same address in one cycle SHALL return old data, unless the forwarding feature (REQ-031) is compiled in.

Reset
REQ-027 rst=0 SHALL set FSM to IDLE and clear index, latched count, out_valid, out_last, drain_done, err_wr_busy, out_data and curr_rd_data.
REQ-028 Reset SHALL NOT clear bank contents.
REQ-029 Reset during DRAIN SHALL abort with no drain_done pulse.
REQ-030 The first drain_start is accepted in the cycle after rst returns to 1.

Configuration
REQ-031 With macro SMEM_STORE_FWD_EN defined, a same-cycle CURR write and read at equal address SHALL return wr_curr_data in curr_rd_data; without it, old data is returned.

Verification
REQ-032 Bench SHALL cover MEM writes to addr 0..3 with data k, then drain_start with count=4 and out_ready=1: out_valid at T+2, data 0..3, out_last on entry 3, drain_done once.
REQ-033 Bench SHALL cover drain of count=2 with out_ready held 0 for 5 cycles: out_data stable, no loss, two beats total.
REQ-034 Bench SHALL cover wr_curr_valid=1 with stall=1 at addr 5 with data 0xAA: read of addr 5 returns previous contents.
REQ-035 Bench SHALL cover a MEM write during DRAIN: entry unchanged, err_wr_busy=1 until reset.
REQ-036 Bench SHALL cover same-cycle CURR write and read at addr 9 with data 0x55: returns 0x55 with SMEM_STORE_FWD_EN, old value without it.
REQ-037 Bench SHALL cover rst=0 in OUT, then drain_start with count=0: FSM IDLE with no out_valid, then a single drain_done pulse.
